vga_timing_gen: RTL and testbench

Generates 800x600 VGA raster timing: horizontal/vertical pixel counters, sync pulses, display-enable and frame/line markers. Sits directly upstream of the banner/sprite renderers: its `o_h_coord`, `o_v_coord` and `o_disp_enbl` drive their `i_h_coord`, `i_v_coord` and `i_disp_enbl`; its syncs go to the VGA connector alongside the renderer's RGB. Advances one pixel per `i_pix_stb`, so the same RTL serves a native pixel clock (strobe tied high) or a divided one.

---
 rtl/vga_timing_gen.sv | 109 ++++++++++
 tb/tb_vga_timing_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 800x600 VGA raster timing generator: pixel/line counters, syncs, display
// enable and line/frame markers, advancing one position per pixel strobe.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BACK   = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BACK   = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_stb,
  output logic [10:0] o_h_coord,
  output logic [9:0]  o_v_coord,
  output logic        o_disp_enbl,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic [7:0]  o_frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_param_check
      $error("vga_timing_gen: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
    end
  endgenerate

  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_DE_END    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG  = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] H_SYNC_END  = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_DE_END    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_BEG  = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0]  V_SYNC_END  = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [10:0] h_nxt;
  logic [9:0]  v_nxt;
  logic        frame_seen;

  logic        next_de;
  logic        next_hs;
  logic        next_vs;
  logic        at_line;
  logic        at_frame;

  // Decode the position about to be registered so every output lands on the
  // same edge. vsync follows v_nxt, which only moves when h_nxt wraps to 0.
  always_comb begin
    next_de  = 1'b0;
    next_hs  = ~SYNC_POL;
    next_vs  = ~SYNC_POL;
    at_line  = 1'b0;
    at_frame = 1'b0;
    if ((h_nxt < H_DE_END) && (v_nxt < V_DE_END)) next_de = 1'b1;
    if ((h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END)) next_hs = SYNC_POL;
    if ((v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END)) next_vs = SYNC_POL;
    if (h_nxt == 11'd0) at_line = 1'b1;
    if ((h_nxt == 11'd0) && (v_nxt == 10'd0)) at_frame = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_nxt         <= '0;
      v_nxt         <= '0;
      frame_seen    <= 1'b0;
      o_h_coord     <= '0;
      o_v_coord     <= '0;
      o_disp_enbl   <= 1'b0;
      o_hsync       <= ~SYNC_POL;
      o_vsync       <= ~SYNC_POL;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_cnt   <= '0;
    end else begin
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      if (i_pix_stb) begin
        o_h_coord     <= h_nxt;
        o_v_coord     <= v_nxt;
        o_disp_enbl   <= next_de;
        o_hsync       <= next_hs;
        o_vsync       <= next_vs;
        o_line_start  <= at_line;
        o_frame_start <= at_frame;
        // The very first (0,0) after reset opens frame 0; nothing completed yet.
        if (at_frame) begin
          frame_seen <= 1'b1;
          if (frame_seen) o_frame_cnt <= o_frame_cnt + 8'd1;
        end
        if (h_nxt == H_LAST) begin
          h_nxt <= '0;
          v_nxt <= (v_nxt == V_LAST) ? 10'd0 : v_nxt + 10'd1;
        end else begin
          h_nxt <= h_nxt + 11'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 800x600 instance for line-level timing and
// a tiny-raster, active-low-sync instance for frame, wrap and reset behaviour.
module tb_vga_timing_gen;

  localparam int W = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, stb_a, rst_b, stb_b;
  logic [10:0] h_a, h_b;
  logic [9:0]  v_a, v_b;
  logic        de_a, hs_a, vs_a, ls_a, fs_a;
  logic        de_b, hs_b, vs_b, ls_b, fs_b;
  logic [7:0]  cnt_a, cnt_b;

  vga_timing_gen dut_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_pix_stb(stb_a),
    .o_h_coord(h_a), .o_v_coord(v_a), .o_disp_enbl(de_a),
    .o_hsync(hs_a), .o_vsync(vs_a), .o_line_start(ls_a),
    .o_frame_start(fs_a), .o_frame_cnt(cnt_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1'b0)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_b), .i_pix_stb(stb_b),
    .o_h_coord(h_b), .o_v_coord(v_b), .o_disp_enbl(de_b),
    .o_hsync(hs_b), .o_vsync(vs_b), .o_line_start(ls_b),
    .o_frame_start(fs_b), .o_frame_cnt(cnt_b)
  );

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  int checks = 0;
  int errors = 0;
  int n_a = 0;
  int n_b = 0;

  // Expected outputs after n strobes since reset, derived arithmetically from
  // the strobe index: position p = n-1 within an ht*vt raster.
  function automatic logic [W-1:0] model(input int n, input bit pulse,
      input int ha, input int hf, input int hsw, input int hb,
      input int va, input int vf, input int vsw, input int vb, input bit pol);
    int ht, vt, p, h, v, f;
    logic de, hs, vs, ls, fs;
    if (n == 0) return {11'd0, 10'd0, 1'b0, ~pol, ~pol, 1'b0, 1'b0, 8'd0};
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    p  = n - 1;
    h  = p % ht;
    v  = (p / ht) % vt;
    f  = p / (ht * vt);
    de = (h < ha) && (v < va);
    hs = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
    vs = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
    ls = pulse && (h == 0);
    fs = pulse && (h == 0) && (v == 0);
    return {11'(h), 10'(v), de, hs, vs, ls, fs, 8'(f % 256)};
  endfunction

  function automatic logic [W-1:0] model_a(input int n, input bit pulse);
    return model(n, pulse, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1);
  endfunction

  function automatic logic [W-1:0] model_b(input int n, input bit pulse);
    return model(n, pulse, 8, 2, 3, 2, 6, 1, 2, 1, 1'b0);
  endfunction

  // Driver tasks: set the strobe, let one edge happen, queue what it must yield.
  task automatic step_a(input bit stb);
    stb_a = stb;
    @(posedge clk); #1;
    if (stb && rst_a) n_a++;
    exp_a_q.push_back(model_a(n_a, stb && rst_a));
  endtask

  task automatic step_b(input bit stb);
    stb_b = stb;
    @(posedge clk); #1;
    if (stb && rst_b) n_b++;
    exp_b_q.push_back(model_b(n_b, stb && rst_b));
  endtask

  // Reset asserted between edges; the reset values are expected before any edge.
  task automatic async_reset_b();
    @(posedge clk); #2;
    rst_b = 1'b0;
    n_b = 0;
    exp_b_q.push_back(model_b(0, 1'b0));
  endtask

  task automatic compare(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b cnt=%0d, expected h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b cnt=%0d",
        name, $time, got[33:23], got[22:13], got[12], got[11], got[10], got[9], got[8], got[7:0],
        exp[33:23], exp[22:13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Monitors: outputs are registered, so each clock presents one result,
  // sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (exp_a_q.size() > 0)
      compare("inst_a", {h_a, v_a, de_a, hs_a, vs_a, ls_a, fs_a, cnt_a}, exp_a_q.pop_front());
  end

  initial forever begin
    @(negedge clk);
    if (exp_b_q.size() > 0)
      compare("inst_b", {h_b, v_b, de_b, hs_b, vs_b, ls_b, fs_b, cnt_b}, exp_b_q.pop_front());
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; stb_a = 1'b0; stb_b = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_a = 1'b1; rst_b = 1'b1;

    // Instance A: reset state, idle hold, then two full lines plus a bit.
    step_a(1'b0);
    step_a(1'b0);
    repeat (2100) step_a(1'b1);
    repeat (3) step_a(1'b0);
    repeat (40) begin
      step_a(1'b1);
      step_a(1'b0);
    end
    stb_a = 1'b0;

    // Instance B: 256+ frames continuous covers frame_start recurrence and wrap.
    step_b(1'b0);
    repeat (256 * 150 + 5) step_b(1'b1);
    repeat (160) begin
      step_b(1'b1);
      step_b(1'b0);
    end

    // Mid-frame asynchronous reset, held with the strobe high, then release.
    repeat ($urandom_range(40, 110)) step_b(1'b1);
    async_reset_b();
    step_b(1'b1);
    step_b(1'b1);
    #2 rst_b = 1'b1;
    repeat (200) step_b(1'b1);
    stb_b = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d/%0d entries left, required 0/0", exp_a_q.size(), exp_b_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
